sorted_frame_serializer: RTL and testbench

Downstream stage of the combinational selection sorter. It captures one sorted N-element frame from the sorter's flattened output bus and streams the elements out one per beat over a valid/ready interface, with a last-beat marker. It also checks that each frame is non-decreasing and flags any ordering violation, so the sorter's output can be monitored in-system.

---
 rtl/sorted_frame_serializer_if.sv | 37 +++
 rtl/sorted_frame_serializer.sv | 97 +++++++++
 tb/tb_sorted_frame_serializer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sorted_frame_serializer_if.sv
// ---------------------------------------------------------------------------
// sorted_frame_serializer_if : frame load and element stream bundle
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface sorted_frame_serializer_if #(
  parameter int N     = 5,
  parameter int WIDTH = 8
);
  localparam int IW = $clog2(N);

  logic [N*WIDTH-1:0] frame_in;
  logic               load_valid;
  logic               load_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic [IW-1:0]      out_index;
  logic               frame_done;
  logic               order_err;

  modport master (
    input  frame_in, load_valid, out_ready,
    output load_ready, out_data, out_valid, out_last, out_index,
           frame_done, order_err
  );

  modport slave (
    output frame_in, load_valid, out_ready,
    input  load_ready, out_data, out_valid, out_last, out_index,
           frame_done, order_err
  );
endinterface

`default_nettype wire

// File: rtl/sorted_frame_serializer.sv
// ---------------------------------------------------------------------------
// sorted_frame_serializer : captures an N-element frame, streams it out
// one element per beat and flags any non-decreasing order violation.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sorted_frame_serializer #(
  parameter int N     = 5,
  parameter int WIDTH = 8
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  sorted_frame_serializer_if.master bus
);

  localparam int IW = $clog2(N);

  localparam logic [0:0]    c_idle = 1'b0;
  localparam logic [0:0]    c_send = 1'b1;
  localparam logic [IW-1:0] c_last = IW'(N - 1);
  localparam logic [IW-1:0] c_one  = IW'(1);

  logic [0:0]       r_state;
  logic [0:0]       w_next;
  logic [WIDTH-1:0] r_buf [N];
  logic [IW-1:0]    r_index;
  logic             r_frame_done;
  logic             r_order_err;

  logic             w_send;
  logic             w_last;
  logic             w_xfer;
  logic             w_load_ready;
  logic             w_capture;
  logic             w_viol;
  logic [IW-1:0]    w_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next;
    end
  end

  // A capture on the last accepted beat keeps streaming without a bubble
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:  if (bus.load_valid) w_next = c_send;
      c_send:  if (w_xfer && w_last) w_next = bus.load_valid ? c_send : c_idle;
      default: w_next = c_idle;
    endcase
  end

  always_comb begin
    w_send       = (r_state == c_send);
    w_last       = w_send && (r_index == c_last);
    w_xfer       = w_send && bus.out_ready;
    w_load_ready = rst_n && (!w_send || (w_last && bus.out_ready));
    w_capture    = w_load_ready && bus.load_valid;
    w_prev       = (r_index == '0) ? '0 : (r_index - c_one);
    w_viol       = w_xfer && (r_index != '0) && (r_buf[r_index] < r_buf[w_prev]);
  end

  assign bus.load_ready = w_load_ready;
  assign bus.out_valid  = w_send;
  assign bus.out_last   = w_last;
  assign bus.out_data   = w_send ? r_buf[r_index] : '0;
  assign bus.out_index  = r_index;
  assign bus.frame_done = r_frame_done;
  assign bus.order_err  = r_order_err;

  // A new capture owns order_err, so it wins over a violation on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
      r_index      <= '0;
      r_frame_done <= 1'b0;
      r_order_err  <= 1'b0;
    end else begin
      r_frame_done <= w_xfer && w_last;
      if (w_capture) begin
        for (int i = 0; i < N; i++) r_buf[i] <= bus.frame_in[i*WIDTH +: WIDTH];
        r_index     <= '0;
        r_order_err <= 1'b0;
      end else begin
        if (w_xfer && !w_last) r_index <= r_index + c_one;
        if (w_viol) r_order_err <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sorted_frame_serializer.sv
// ---------------------------------------------------------------------------
// tb_sorted_frame_serializer : directed and random checks against a
// beat-queue reference model. Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sorted_frame_serializer;

  localparam int N = 5;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sorted_frame_serializer_if #(.N(N), .WIDTH(W)) ifc ();

  sorted_frame_serializer #(.N(N), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  typedef struct {
    logic [W-1:0] v;
    int           idx;
    bit           viol;
  } beat_t;

  beat_t q[$];
  bit    m_err;
  bit    m_done;
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] mk(input int a0, a1, a2, a3, a4);
    return {W'(a4), W'(a3), W'(a2), W'(a1), W'(a0)};
  endfunction

  function automatic logic [N*W-1:0] rand_frame(input bit sorted);
    int a[N];
    logic [N*W-1:0] f;
    for (int i = 0; i < N; i++) a[i] = int'($urandom_range(0, 255));
    if (sorted) a.sort();
    for (int i = 0; i < N; i++) f[i*W +: W] = W'(a[i]);
    return f;
  endfunction

  task automatic model_reset();
    q.delete();
    m_err  = 1'b0;
    m_done = 1'b0;
  endtask

  // One clock: drive at negedge, check outputs, then advance the model
  task automatic cycle(input bit lv, input logic [N*W-1:0] f, input bit rdy, output bit captured);
    bit    exp_lr;
    beat_t b;
    ifc.load_valid = lv;
    ifc.frame_in   = f;
    ifc.out_ready  = rdy;
    #1;
    exp_lr = (q.size() == 0) || (q.size() == 1 && rdy);
    chk("load_ready", 32'(ifc.load_ready), 32'(exp_lr));
    chk("out_valid", 32'(ifc.out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_data", 32'(ifc.out_data), 32'(q[0].v));
      chk("out_index", 32'(ifc.out_index), 32'(q[0].idx));
      chk("out_last", 32'(ifc.out_last), 32'(q[0].idx == N - 1));
    end
    chk("frame_done", 32'(ifc.frame_done), 32'(m_done));
    chk("order_err", 32'(ifc.order_err), 32'(m_err));
    m_done = 1'b0;
    if (q.size() != 0 && rdy) begin
      b = q.pop_front();
      if (b.viol) m_err = 1'b1;
      if (b.idx == N - 1) m_done = 1'b1;
    end
    captured = lv && exp_lr;
    if (captured) begin
      m_err = 1'b0;
      for (int i = 0; i < N; i++) begin
        b.v    = f[i*W +: W];
        b.idx  = i;
        b.viol = (i > 0) && (f[i*W +: W] < f[(i-1)*W +: W]);
        q.push_back(b);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    bit c;
    for (int k = 0; k < n; k++) cycle(1'b0, '0, rdy, c);
  endtask

  initial begin
    bit c;
    bit cap_b;
    logic [N*W-1:0] fa;
    logic [N*W-1:0] fb;

    ifc.load_valid = 1'b0;
    ifc.frame_in   = '0;
    ifc.out_ready  = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_load_ready", 32'(ifc.load_ready), 32'h0);
    chk("rst_out_valid", 32'(ifc.out_valid), 32'h0);
    chk("rst_out_last", 32'(ifc.out_last), 32'h0);
    chk("rst_out_data", 32'(ifc.out_data), 32'h0);
    chk("rst_out_index", 32'(ifc.out_index), 32'h0);
    chk("rst_frame_done", 32'(ifc.frame_done), 32'h0);
    chk("rst_order_err", 32'(ifc.order_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic stream
    fa = mk(10, 20, 30, 40, 50);
    cycle(1'b1, fa, 1'b1, c);
    chk("basic_captured", 32'(c), 32'h1);
    idle(7, 1'b1);

    // Backpressure 1,0,0 pattern
    cycle(1'b1, fa, 1'b1, c);
    for (int k = 0; k < 15; k++) cycle(1'b0, '0, (k % 3) == 0, c);
    idle(2, 1'b1);

    // Order error, then a clean frame clears it
    cycle(1'b1, mk(10, 30, 20, 40, 50), 1'b1, c);
    idle(8, 1'b1);
    cycle(1'b1, mk(1, 2, 3, 4, 5), 1'b1, c);
    idle(7, 1'b1);

    // Back-to-back frames with equal neighbours
    fa = mk(1, 2, 3, 4, 5);
    fb = mk(6, 7, 8, 9, 9);
    cycle(1'b1, fa, 1'b1, c);
    cap_b = 1'b0;
    for (int k = 0; k < 20 && !cap_b; k++) cycle(1'b1, fb, 1'b1, cap_b);
    chk("b2b_captured", 32'(cap_b), 32'h1);
    idle(7, 1'b1);

    // Load presented mid-frame is ignored
    cycle(1'b1, mk(11, 12, 13, 14, 15), 1'b1, c);
    cycle(1'b1, mk(99, 99, 99, 99, 99), 1'b1, c);
    chk("ignored_load", 32'(c), 32'h0);
    cycle(1'b1, mk(99, 99, 99, 99, 99), 1'b0, c);
    cycle(1'b1, mk(99, 99, 99, 99, 99), 1'b1, c);
    chk("ignored_load2", 32'(c), 32'h0);
    idle(6, 1'b1);

    // Reset mid-frame after two beats
    cycle(1'b1, mk(21, 22, 23, 24, 25), 1'b1, c);
    idle(2, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ifc.out_valid), 32'h0);
    chk("midrst_load_ready", 32'(ifc.load_ready), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst_load_ready", 32'(ifc.load_ready), 32'h1);
    chk("postrst_index", 32'(ifc.out_index), 32'h0);
    chk("postrst_frame_done", 32'(ifc.frame_done), 32'h0);
    cycle(1'b1, mk(31, 32, 33, 34, 35), 1'b1, c);
    idle(7, 1'b1);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 2) != 0, rand_frame($urandom_range(0, 1) == 1),
            $urandom_range(0, 3) != 0, c);
    end
    idle(8, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
